// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl - hazard and sequencing controller for the 5-stage
// Fetch/Decode/Execute/Mem/Writeback pipeline.
//
// Purpose:
//   - Per-stage stall and flush strobes for load-use and branch-compare hazards.
//   - Operand-forwarding selects for Execute and for the Decode comparator.
//   - Multi-cycle mult/div occupancy of Execute (MD_BUSY).
//   - Drain-then-halt sequencing on a syscall decoded in Decode (DRAIN, HALT).
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   rsD, rtD / rsE, rtE              source registers in Decode / Execute
//   writeRegE/M/W, regWriteE/M/W     destination register and write enable per stage
//   memToRegE, memToRegM             instruction in E / M is a load
//   branchD, jumpD, branchTakenD     control-flow information from Decode
//   syscallD                         halting syscall in Decode
//   mdStartE                         mult/div instruction in Execute
//   stallF, stallD, stallE           hold the stage register
//   flushD, flushE, flushM           clear the stage register
//   forwardAE, forwardBE             00 = register file, 01 = Writeback, 10 = Mem
//   forwardAD, forwardBD             forward the Mem result to the Decode comparator
//   busyE                            mult/div in progress
//   halted                           pipeline halted
//   stallCycles, flushCount          saturating performance counters
//                                    (only with HAZ_PERF_CNT_EN defined)
//
// Optional feature macro: HAZ_PERF_CNT_EN

module pipe_hazard_ctrl #(
   parameter int unsigned MD_LATENCY   = 32,
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned REG_ADDR_W   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] rsD,
   input  logic [REG_ADDR_W-1:0] rtD,
   input  logic [REG_ADDR_W-1:0] rsE,
   input  logic [REG_ADDR_W-1:0] rtE,
   input  logic [REG_ADDR_W-1:0] writeRegE,
   input  logic [REG_ADDR_W-1:0] writeRegM,
   input  logic [REG_ADDR_W-1:0] writeRegW,
   input  logic                  regWriteE,
   input  logic                  regWriteM,
   input  logic                  regWriteW,
   input  logic                  memToRegE,
   input  logic                  memToRegM,
   input  logic                  branchD,
   input  logic                  jumpD,
   input  logic                  branchTakenD,
   input  logic                  syscallD,
   input  logic                  mdStartE,
   output logic                  stallF,
   output logic                  stallD,
   output logic                  stallE,
   output logic                  flushD,
   output logic                  flushE,
   output logic                  flushM,
   output logic [1:0]            forwardAE,
   output logic [1:0]            forwardBE,
   output logic                  forwardAD,
   output logic                  forwardBD,
   output logic                  busyE,
`ifdef HAZ_PERF_CNT_EN
   output logic [31:0]           stallCycles,
   output logic [31:0]           flushCount,
`endif
   output logic                  halted
);

   typedef enum logic [1:0] {RUN, MD_BUSY, DRAIN, HALT} state_t;

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       lw_stall, br_stall;

   // ---------------------------------------------------------------
   // Forwarding (combinational in every state, register 0 never hits)
   // ---------------------------------------------------------------
   always_comb begin
      forwardAE = 2'b00;
      forwardBE = 2'b00;
      forwardAD = 1'b0;
      forwardBD = 1'b0;
      if (!reset) begin
         if (regWriteM && (writeRegM != '0) && (writeRegM == rsE))
            forwardAE = 2'b10;
         else if (regWriteW && (writeRegW != '0) && (writeRegW == rsE))
            forwardAE = 2'b01;

         if (regWriteM && (writeRegM != '0) && (writeRegM == rtE))
            forwardBE = 2'b10;
         else if (regWriteW && (writeRegW != '0) && (writeRegW == rtE))
            forwardBE = 2'b01;

         forwardAD = regWriteM && (writeRegM != '0) && (writeRegM == rsD);
         forwardBD = regWriteM && (writeRegM != '0) && (writeRegM == rtD);
      end
   end

   // ---------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------
   always_comb begin
      lw_stall = memToRegE && regWriteE &&
                 ((writeRegE == rsD) || (writeRegE == rtD));
      // Branch compares in Decode: result still in E, or a load still in M.
      br_stall = branchD &&
                 ((regWriteE && ((writeRegE == rsD) || (writeRegE == rtD))) ||
                  (memToRegM && ((writeRegM == rsD) || (writeRegM == rtD))));
   end

   // ---------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // ---------------------------------------------------------------
   // FSM next-state and strobe outputs
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushM    = 1'b0;
      busyE     = 1'b0;
      halted    = 1'b0;

      unique case (state)
         RUN: begin
            if (mdStartE) begin
               stallF    = 1'b1;
               stallD    = 1'b1;
               stallE    = 1'b1;
               flushM    = 1'b1;
               state_nxt = MD_BUSY;
               cnt_nxt   = 8'(MD_LATENCY - 1);
            end else if (lw_stall || br_stall) begin
               stallF = 1'b1;
               stallD = 1'b1;
               flushE = 1'b1;
            end else if (syscallD) begin
               stallF    = 1'b1;
               stallD    = 1'b1;
               flushE    = 1'b1;
               state_nxt = DRAIN;
               cnt_nxt   = 8'(DRAIN_CYCLES - 1);
            end else if (jumpD || (branchD && branchTakenD)) begin
               flushD = 1'b1;
            end
         end

         MD_BUSY: begin
            busyE = 1'b1;
            if (cnt > 8'd1) begin
               stallF  = 1'b1;
               stallD  = 1'b1;
               stallE  = 1'b1;
               flushM  = 1'b1;
               cnt_nxt = cnt - 8'd1;
            end else begin
               // Final cycle: release the stalls so the instruction advances.
               state_nxt = RUN;
            end
         end

         DRAIN: begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
            if (cnt == 8'd0)
               state_nxt = HALT;
            else
               cnt_nxt = cnt - 8'd1;
         end

         HALT: begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
            halted = 1'b1;
         end

         default: state_nxt = RUN;
      endcase

      // Reset forces bubbles into every stage without waiting for a clock.
      if (reset) begin
         stallF = 1'b0;
         stallD = 1'b0;
         stallE = 1'b0;
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
         busyE  = 1'b0;
         halted = 1'b0;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   // ---------------------------------------------------------------
   // Saturating performance counters
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stallCycles <= '0;
         flushCount  <= '0;
      end else begin
         if (stallF && (stallCycles != '1))
            stallCycles <= stallCycles + 32'd1;
         if (flushD && (flushCount != '1))
            flushCount <= flushCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl - directed bench for pipe_hazard_ctrl
// (MD_LATENCY = 4, DRAIN_CYCLES = 3, REG_ADDR_W = 5).
// Inputs change 1 time unit after the rising edge; outputs are checked
// 1 time unit later, well away from either clock edge.

module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
   logic       regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
   logic       branchD, jumpD, branchTakenD, syscallD, mdStartE;
   logic       stallF, stallD, stallE, flushD, flushE, flushM;
   logic [1:0] forwardAE, forwardBE;
   logic       forwardAD, forwardBD, busyE, halted;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stallCycles, flushCount;
`endif

   int checks = 0;
   int errors = 0;

   // {stallF, stallD, stallE, flushD, flushE, flushM, busyE, halted}
   logic [7:0] ctrl;
   // {forwardAE, forwardBE, forwardAD, forwardBD}
   logic [5:0] fwd;
   assign ctrl = {stallF, stallD, stallE, flushD, flushE, flushM, busyE, halted};
   assign fwd  = {forwardAE, forwardBE, forwardAD, forwardBD};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .MD_LATENCY  (4),
      .DRAIN_CYCLES(3),
      .REG_ADDR_W  (5)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rsD         (rsD),
      .rtD         (rtD),
      .rsE         (rsE),
      .rtE         (rtE),
      .writeRegE   (writeRegE),
      .writeRegM   (writeRegM),
      .writeRegW   (writeRegW),
      .regWriteE   (regWriteE),
      .regWriteM   (regWriteM),
      .regWriteW   (regWriteW),
      .memToRegE   (memToRegE),
      .memToRegM   (memToRegM),
      .branchD     (branchD),
      .jumpD       (jumpD),
      .branchTakenD(branchTakenD),
      .syscallD    (syscallD),
      .mdStartE    (mdStartE),
      .stallF      (stallF),
      .stallD      (stallD),
      .stallE      (stallE),
      .flushD      (flushD),
      .flushE      (flushE),
      .flushM      (flushM),
      .forwardAE   (forwardAE),
      .forwardBE   (forwardBE),
      .forwardAD   (forwardAD),
      .forwardBD   (forwardBD),
      .busyE       (busyE),
`ifdef HAZ_PERF_CNT_EN
      .stallCycles (stallCycles),
      .flushCount  (flushCount),
`endif
      .halted      (halted)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      rsD = '0; rtD = '0; rsE = '0; rtE = '0;
      writeRegE = '0; writeRegM = '0; writeRegW = '0;
      regWriteE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
      memToRegE = 1'b0; memToRegM = 1'b0;
      branchD = 1'b0; jumpD = 1'b0; branchTakenD = 1'b0;
      syscallD = 1'b0; mdStartE = 1'b0;
   endtask

   // Watchdog: the directed sequence is short; anything this long is a hang.
   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- reset state ----------------
      clr();
      reset = 1'b1;
      regWriteM = 1'b1; writeRegM = 5'd5; rsE = 5'd5; rtE = 5'd5; rsD = 5'd5;
      #2;
      chk("rst_ctrl", ctrl, 8'b000_111_00);
      chk("rst_fwd", {2'b00, fwd}, 8'h00);
      tick();
      tick();
      clr();
      reset = 1'b0;
      #1;
      chk("run_idle", ctrl, 8'b000_000_00);

      // ---------------- load-use on rs ----------------
      tick();
      memToRegE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd8; rsD = 5'd8;
      #1;
      chk("lw_stall", ctrl, 8'b110_010_00);
      tick();
      clr();
      rsE = 5'd8; writeRegM = 5'd8; regWriteM = 1'b1; memToRegM = 1'b1;
      #1;
      chk("lw_after_ctrl", ctrl, 8'b000_000_00);
      chk("lw_after_fwd", {2'b00, fwd}, {2'b00, 2'b10, 2'b00, 1'b0, 1'b0});

      // ---------------- forwarding ----------------
      tick();
      clr();
      regWriteM = 1'b1; writeRegM = 5'd0; rsE = 5'd0; rtE = 5'd0; rsD = 5'd0;
      #1;
      chk("fwd_r0", {2'b00, fwd}, 8'h00);
      writeRegM = 5'd5; writeRegW = 5'd5; regWriteW = 1'b1; rsE = 5'd5;
      #1;
      chk("fwd_mem_prio", {2'b00, fwd}, {2'b00, 2'b10, 2'b00, 1'b0, 1'b0});
      regWriteM = 1'b0; rtE = 5'd5;
      #1;
      chk("fwd_wb", {2'b00, fwd}, {2'b00, 2'b01, 2'b01, 1'b0, 1'b0});
      regWriteM = 1'b1; writeRegM = 5'd7; rsD = 5'd7; rtD = 5'd7;
      #1;
      chk("fwd_decode", {2'b00, fwd}, {2'b00, 2'b01, 2'b01, 1'b1, 1'b1});

      // ---------------- taken branch, no hazard ----------------
      tick();
      clr();
      branchD = 1'b1; branchTakenD = 1'b1; rsD = 5'd3; rtD = 5'd4;
      #1;
      chk("br_taken", ctrl, 8'b000_100_00);
      tick();
      clr();
      #1;
      chk("br_taken_after", ctrl, 8'b000_000_00);

      // ---------------- branch with E-stage dependency ----------------
      tick();
      branchD = 1'b1; branchTakenD = 1'b1; rsD = 5'd3; rtD = 5'd4;
      regWriteE = 1'b1; writeRegE = 5'd3;
      #1;
      chk("br_haz_stall", ctrl, 8'b110_010_00);
      tick();
      regWriteE = 1'b0; writeRegE = 5'd0;
      regWriteM = 1'b1; writeRegM = 5'd3;
      #1;
      chk("br_haz_flush", ctrl, 8'b000_100_00);
      chk("br_haz_fwdAD", {7'b0, forwardAD}, 8'h01);

      // ---------------- mult/div, MD_LATENCY = 4 ----------------
      tick();
      clr();
      mdStartE = 1'b1;
      #1;
      chk("md_c0", ctrl, 8'b111_001_00);
      tick();
      #1;
      chk("md_c1", ctrl, 8'b111_001_10);
      tick();
      #1;
      chk("md_c2", ctrl, 8'b111_001_10);
      tick();
      #1;
      chk("md_c3", ctrl, 8'b000_000_10);
      tick();
      mdStartE = 1'b0;
      #1;
      chk("md_done", ctrl, 8'b000_000_00);

      // ---------------- reset in the middle of MD_BUSY ----------------
      tick();
      mdStartE = 1'b1;
      #1;
      chk("mdab_c0", ctrl, 8'b111_001_00);
      tick();
      mdStartE = 1'b0;
      #1;
      chk("mdab_c1", ctrl, 8'b111_001_10);
      reset = 1'b1;
      #1;
      chk("mdab_reset", ctrl, 8'b000_111_00);
      reset = 1'b0;
      #1;
      chk("mdab_release", ctrl, 8'b000_000_00);
      tick();
      #1;
      chk("mdab_run", ctrl, 8'b000_000_00);

      // ---------------- syscall behind a load-use stall ----------------
      tick();
      syscallD = 1'b1;
      memToRegE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd9; rsD = 5'd9;
      #1;
      chk("sys_lw", ctrl, 8'b110_010_00);
      tick();
      memToRegE = 1'b0; regWriteE = 1'b0; writeRegE = 5'd0;
      #1;
      chk("sys_c0", ctrl, 8'b110_010_00);
      tick();
      syscallD = 1'b0;
      #1;
      chk("sys_drain1", ctrl, 8'b110_010_00);
      tick();
      #1;
      chk("sys_drain2", ctrl, 8'b110_010_00);
      tick();
      #1;
      chk("sys_drain3", ctrl, 8'b110_010_00);
      tick();
      #1;
      chk("sys_halt", ctrl, 8'b111_001_01);
      tick();
      mdStartE = 1'b1; jumpD = 1'b1;
      #1;
      chk("sys_halt_hold1", ctrl, 8'b111_001_01);
      tick();
      tick();
      #1;
      chk("sys_halt_hold2", ctrl, 8'b111_001_01);

      // ---------------- reset leaves HALT ----------------
      clr();
      reset = 1'b1;
      #1;
      chk("halt_reset", ctrl, 8'b000_111_00);
      tick();
      reset = 1'b0;
      #1;
      chk("halt_released", ctrl, 8'b000_000_00);
      tick();
      jumpD = 1'b1;
      #1;
      chk("post_jump", ctrl, 8'b000_100_00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
